matrix_load_ctrl: RTL

MATRIX_LOAD_CTRL -- requirements
Module: matrix_load_ctrl

---
 rtl/matrix_ctrl_pkg.sv | 17 +
 rtl/matrix_buf.sv | 34 +++
 rtl/matrix_load_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/matrix_ctrl_pkg.sv
// Shared definitions for the matrix load controller.
//   state_e        - controller FSM states
//   DEF_DATA_W     - default element width
//   DEF_DEPTH      - default number of elements per matrix
package matrix_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/matrix_buf.sv
// Element storage for one matrix: DEPTH x DATA_W register file.
//   clk      - clock
//   wr_en    - write strobe, captured on the rising edge
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - combinational read data (mem[rd_addr])
// Storage has no reset; contents are only meaningful after a full load.
module matrix_buf
    import matrix_ctrl_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/matrix_load_ctrl.sv
// Matrix load/drain controller: collects DEPTH elements from the load
// handshake into a buffer, then streams them out in index order.
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, abort          - begin a sequence (from IDLE) / cancel any sequence
//   in_valid/in_data/in_ready          - element load handshake
//   out_valid/out_data/out_idx/out_ready - element stream toward the datapath
//   busy                  - high while loading or draining
//   done                  - one-cycle completion pulse
//   load_count            - elements stored in the current sequence
module matrix_load_ctrl
    import matrix_ctrl_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  DEPTH  = DEF_DEPTH,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W:0]    load_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W:0]   load_count_q, load_count_d;
    logic             buf_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            load_count_q <= load_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        load_count_d = load_count_q;
        buf_we       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    load_count_d = '0;
                end
            end
            ST_LOAD: begin
                // in_ready is unconditionally high here, so in_valid alone
                // marks a transfer.
                if (in_valid) begin
                    buf_we       = 1'b1;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle load handshake
        // (the element is dropped, the buffer is left untouched).
        if (abort) begin
            state_d      = ST_IDLE;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            load_count_d = '0;
            buf_we       = 1'b0;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DRAIN);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign out_idx    = rd_ptr_q;
    assign load_count = load_count_q;

    matrix_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (out_data)
    );

endmodule
